// File: rtl/uart_packet_tx_if.sv
// Host-side write port of the packet transmitter: byte + end-of-packet tag in,
// FIFO occupancy and drop indication out.
interface uart_packet_tx_if #(
  parameter int FifoDepth = 16
);
  logic                         wr_en;
  logic [7:0]                   wr_data;
  logic                         wr_eop;
  logic                         full;
  logic                         overflow;
  logic [$clog2(FifoDepth):0]   fifo_count;

  modport master (
    output wr_en, wr_data, wr_eop,
    input  full, overflow, fifo_count
  );

  modport slave (
    input  wr_en, wr_data, wr_eop,
    output full, overflow, fifo_count
  );
endinterface

// File: rtl/uart_packet_tx.sv
// FIFO-buffered 8N2 transmitter; frames go out back-to-back within a packet and the
// line is held idle for GapBits bit-times after an end-of-packet byte.

module uart_packet_tx_fifo #(
  parameter int Width = 9,
  parameter int Depth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [Width-1:0]           push_dat,
  input  logic                       pop,
  output logic [Width-1:0]           pop_dat,
  output logic [$clog2(Depth):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             accept;
  logic [CntW-1:0]  count_nxt;

  // Acceptance looks at the pre-pop count, so a full FIFO drops even when popping.
  assign accept    = push && (count != CntW'(Depth));
  assign count_nxt = count + CntW'(accept) - CntW'(pop);
  assign pop_dat   = mem[rd_ptr];
  assign empty     = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)    rd_ptr <= rd_ptr + PtrW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == CntW'(Depth));
      overflow <= push && !accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_dat;
  end
endmodule

module uart_packet_tx #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 9600,
  parameter int FifoDepth    = 16,
  parameter int GapBits      = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_packet_tx_if.slave  host,
  output logic             TxD,
  output logic             busy
);
  localparam int AccWidth = $clog2(ClkFrequency / Baud) + 8;
  localparam logic [63:0] IncFull =
    ((64'(Baud) << AccWidth) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
  localparam logic [AccWidth-1:0] Inc = IncFull[AccWidth-1:0];
  localparam int GapW = $clog2(GapBits);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP1 = 3'd3;
  localparam logic [2:0] STOP2 = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  logic [2:0]          state, state_nxt;
  logic [7:0]          shift, shift_nxt;
  logic [2:0]          bit_idx, bit_idx_nxt;
  logic                eop_latched, eop_nxt;
  logic [GapW-1:0]     gap_cnt, gap_nxt;
  logic                txd_nxt;
  logic [AccWidth-1:0] acc;
  logic [AccWidth:0]   acc_sum;
  logic                tick;

  logic                pop;
  logic [8:0]          fifo_dat;
  logic                fifo_empty;

  uart_packet_tx_fifo #(
    .Width (9),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (host.wr_en),
    .push_dat ({host.wr_eop, host.wr_data}),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .count    (host.fifo_count),
    .full     (host.full),
    .empty    (fifo_empty),
    .overflow (host.overflow)
  );

  // Bit timing: the carry of a fractional accumulator; idle keeps it cleared so
  // every frame starts with a full-length start bit.
  assign acc_sum = {1'b0, acc} + {1'b0, Inc};
  assign tick    = acc_sum[AccWidth];

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) acc <= '0;
    else                      acc <= acc_sum[AccWidth-1:0];
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_idx_nxt = bit_idx;
    eop_nxt     = eop_latched;
    gap_nxt     = gap_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dat[7:0];
          eop_nxt   = fifo_dat[8];
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP1;
        end
      end
      STOP1: begin
        if (tick) state_nxt = STOP2;
      end
      STOP2: begin
        if (tick) begin
          if (eop_latched) begin
            state_nxt = GAP;
            gap_nxt   = '0;
          end else if (!fifo_empty) begin
            // Back-to-back: reload straight into the next start bit.
            pop       = 1'b1;
            shift_nxt = fifo_dat[7:0];
            eop_nxt   = fifo_dat[8];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt == GapW'(GapBits - 1)) state_nxt = IDLE;
          else                               gap_nxt   = gap_cnt + GapW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // TxD is registered from the next-state view so the line changes with the state.
  always_comb begin
    txd_nxt = 1'b1;
    if (state_nxt == START)     txd_nxt = 1'b0;
    else if (state_nxt == DATA) txd_nxt = shift_nxt[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      bit_idx     <= '0;
      eop_latched <= 1'b0;
      gap_cnt     <= '0;
      TxD         <= 1'b1;
    end else begin
      state       <= state_nxt;
      shift       <= shift_nxt;
      bit_idx     <= bit_idx_nxt;
      eop_latched <= eop_nxt;
      gap_cnt     <= gap_nxt;
      TxD         <= txd_nxt;
    end
  end

  assign busy = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx at 16 clocks/bit, 4-entry FIFO, 4-bit gap.
module tb_uart_packet_tx;
  localparam int ClkHz   = 1600;
  localparam int BaudR   = 100;
  localparam int Depth   = 4;
  localparam int GapB    = 4;
  localparam int BitClks = 16;

  logic clk = 1'b0;
  logic rst;
  logic txd;
  logic busy;

  uart_packet_tx_if #(.FifoDepth(Depth)) host ();

  uart_packet_tx #(
    .ClkFrequency (ClkHz),
    .Baud         (BaudR),
    .FifoDepth    (Depth),
    .GapBits      (GapB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (host),
    .TxD  (txd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host.wr_en   = 1'b0;
    host.wr_data = '0;
    host.wr_eop  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    cyc = 0;
  endtask

  task automatic put(input logic [7:0] d, input logic eop);
    host.wr_en   = 1'b1;
    host.wr_data = d;
    host.wr_eop  = eop;
    step();
    host.wr_en   = 1'b0;
  endtask

  // Line-level receiver: waits for a start bit, samples mid-bit, ends mid stop2.
  task automatic rx_byte(output logic [7:0] d, output int idle, output bit ok);
    idle = 0;
    ok   = 1'b0;
    d    = '0;
    while (txd === 1'b1 && idle < 2000) begin
      step();
      idle++;
    end
    if (txd !== 1'b0) return;
    repeat (BitClks / 2) step();
    if (txd !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BitClks) step();
      d[i] = txd;
    end
    repeat (BitClks) step();
    if (txd !== 1'b1) return;
    repeat (BitClks) step();
    if (txd !== 1'b1) return;
    ok = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a5_bits [8];
    logic [7:0] rx_d;
    int         idle;
    bit         ok;
    int         lows;
    int         busy_hi;
    int         eop_pulses;

    a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    do_reset();
    chk("rst_txd", txd, 1);
    chk("rst_full", host.full, 0);
    chk("rst_ovf", host.overflow, 0);
    chk("rst_count", host.fifo_count, 0);
    chk("rst_busy", busy, 0);

    // Single byte 0xA5: start 2..17, data bits 16 clocks each, stop 146..177
    put(8'hA5, 1'b0);
    chk("a5_count_c1", host.fifo_count, 1);
    chk("a5_txd_c1", txd, 1);
    chk("a5_busy_c1", busy, 1);
    run_to(2);
    chk("a5_start_first", txd, 0);
    run_to(17);
    chk("a5_start_last", txd, 0);
    for (int i = 0; i < 8; i++) begin
      run_to(18 + 16 * i);
      chk($sformatf("a5_bit%0d_first", i), txd, a5_bits[i]);
      run_to(33 + 16 * i);
      chk($sformatf("a5_bit%0d_last", i), txd, a5_bits[i]);
    end
    run_to(146);
    chk("a5_stop1", txd, 1);
    run_to(177);
    chk("a5_stop2_txd", txd, 1);
    chk("a5_busy_c177", busy, 1);
    run_to(178);
    chk("a5_busy_c178", busy, 0);
    chk("a5_count_end", host.fifo_count, 0);

    // Back-to-back 0x00, 0xFF: second start exactly 176 clocks later
    do_reset();
    put(8'h00, 1'b0);
    put(8'hFF, 1'b0);
    chk("b2b_count_c2", host.fifo_count, 1);
    chk("b2b_start0", txd, 0);
    run_to(26);
    chk("b2b_00_bit0", txd, 0);
    run_to(177);
    chk("b2b_stop2_end", txd, 1);
    run_to(178);
    chk("b2b_start1", txd, 0);
    run_to(193);
    chk("b2b_start1_last", txd, 0);
    run_to(194);
    chk("b2b_ff_bit0", txd, 1);

    // 0x55 with eop, 0x33 queued during STOP1: 64-clock gap plus the idle pop cycle
    do_reset();
    put(8'h55, 1'b1);
    run_to(150);
    put(8'h33, 1'b0);
    chk("gap_count_c151", host.fifo_count, 1);
    run_to(177);
    chk("gap_stop2", txd, 1);
    run_to(178);
    lows = 0;
    for (int k = 0; k < 65; k++) begin
      if (txd !== 1'b1) lows++;
      step();
    end
    chk("gap_lows", lows, 0);
    chk("gap_next_start", txd, 0);
    rx_byte(rx_d, idle, ok);
    chk("gap_rx_ok", ok, 1);
    chk("gap_rx_data", rx_d, 8'h33);

    // Six writes back to back: FIFO fills, sixth dropped
    do_reset();
    for (int i = 0; i < 5; i++) put(8'h11 + 8'(i), 1'b0);
    chk("ovf_count_c5", host.fifo_count, 4);
    chk("ovf_full_c5", host.full, 1);
    chk("ovf_pulse_c5", host.overflow, 0);
    put(8'h16, 1'b0);
    chk("ovf_pulse_c6", host.overflow, 1);
    chk("ovf_count_c6", host.fifo_count, 4);
    step();
    chk("ovf_pulse_c7", host.overflow, 0);
    for (int i = 0; i < 5; i++) begin
      rx_byte(rx_d, idle, ok);
      chk($sformatf("ovf_rx%0d_ok", i), ok, 1);
      chk($sformatf("ovf_rx%0d_data", i), rx_d, 8'h11 + 8'(i));
    end
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      if (txd !== 1'b1) lows++;
      step();
    end
    chk("ovf_no_sixth", lows, 0);
    chk("ovf_busy_end", busy, 0);

    // Reset during DATA bit 3 of 0xC3 with two bytes queued
    do_reset();
    put(8'hC3, 1'b0);
    put(8'hAA, 1'b0);
    put(8'hBB, 1'b0);
    run_to(70);
    chk("mid_count", host.fifo_count, 2);
    chk("mid_bit3", txd, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_count", host.fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    lows = 0;
    busy_hi = 0;
    for (int k = 0; k < 400; k++) begin
      if (txd !== 1'b1) lows++;
      if (busy !== 1'b0) busy_hi++;
      step();
    end
    chk("mid_quiet_txd", lows, 0);
    chk("mid_quiet_busy", busy_hi, 0);

    // Packet {0x10, 0x20, 0x30 eop}: idle-gap detector must fire only after 0x30
    do_reset();
    put(8'h10, 1'b0);
    put(8'h20, 1'b0);
    put(8'h30, 1'b1);
    eop_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      rx_byte(rx_d, idle, ok);
      chk($sformatf("pkt_rx%0d_ok", i), ok, 1);
      chk($sformatf("pkt_rx%0d_data", i), rx_d, 8'h10 * 8'(i + 1));
      if (i > 0 && idle >= 40) eop_pulses++;
    end
    chk("pkt_no_inner_eop", eop_pulses, 0);
    idle = 0;
    while (txd === 1'b1 && idle < 100) begin
      step();
      idle++;
    end
    if (idle >= 40) eop_pulses++;
    chk("pkt_eop_pulses", eop_pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
